mod2011_seq_reducer: RTL and testbench

MOD2011_SEQ_REDUCER -- requirements
Module: mod2011_seq_reducer

---
 rtl/mod2011_seq_reducer_if.sv | 23 ++
 rtl/mod2011_seq_reducer.sv | 135 +++++++++++++
 tb/tb_mod2011_seq_reducer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mod2011_seq_reducer_if.sv
// Operand/residue handshake bundle for the sequential mod-2011 reducer.
interface mod2011_seq_reducer_if;
  localparam int unsigned OP_W  = 36;
  localparam int unsigned RES_W = 11;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_x;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_r;
  logic             busy;

  modport slave (
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_r, busy
  );

  modport master (
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_r, busy
  );
endinterface

// File: rtl/mod2011_seq_reducer.sv
// Reduces a 36-bit operand modulo 2011, one 6-bit chunk per cycle, LSB chunk first.
// Each chunk is mapped through a per-position residue table and accumulated mod 2011.
module mod2011_seq_reducer (
  input  logic                  clk,
  input  logic                  rst,
  mod2011_seq_reducer_if.slave  bus
);
  localparam int unsigned MOD     = 2011;
  localparam int unsigned CHUNK_W = 6;
  localparam int unsigned OP_W    = 36;
  localparam int unsigned NCHUNK  = OP_W / CHUNK_W;
  localparam int unsigned RES_W   = 11;
  localparam int unsigned SUM_W   = 12;
  localparam int unsigned PROD_W  = 17;
  localparam int unsigned K_W     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   opnd_q, opnd_d;
  logic [RES_W-1:0]  acc_q, acc_d;
  logic [K_W-1:0]    k_q, k_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic [RES_W-1:0]  out_r_q, out_r_d;

  // 64^pos mod 2011 for chunk positions 0..5
  function automatic logic [RES_W-1:0] pos_weight(input logic [K_W-1:0] pos);
    logic [RES_W-1:0] w;
    case (pos)
      3'd0:    w = 11'd1;
      3'd1:    w = 11'd64;
      3'd2:    w = 11'd74;
      3'd3:    w = 11'd714;
      3'd4:    w = 11'd1454;
      3'd5:    w = 11'd550;
      default: w = 11'd0;
    endcase
    return w;
  endfunction

  function automatic logic [RES_W-1:0] pos_residue(input logic [K_W-1:0]     pos,
                                                   input logic [CHUNK_W-1:0] chunk);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(chunk) * PROD_W'(pos_weight(pos));
    return RES_W'(prod % PROD_W'(MOD));
  endfunction

  logic [RES_W-1:0] term_tbl [NCHUNK];
  logic [RES_W-1:0] term;
  logic [SUM_W-1:0] sum;
  logic [RES_W-1:0] acc_mod;

  // One residue table per chunk position, all fed from the latched operand
  always_comb begin
    for (int i = 0; i < int'(NCHUNK); i++) begin
      term_tbl[i] = pos_residue(K_W'(i), opnd_q[i*CHUNK_W +: CHUNK_W]);
    end
  end

  always_comb begin
    term    = (k_q < K_W'(NCHUNK)) ? term_tbl[k_q] : '0;
    sum     = SUM_W'(acc_q) + SUM_W'(term);
    acc_mod = (sum >= SUM_W'(MOD)) ? RES_W'(sum - SUM_W'(MOD)) : RES_W'(sum);
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    k_d     = k_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          opnd_d  = bus.in_x;
          acc_d   = '0;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_mod;
        k_d   = k_q + K_W'(1);
        if (k_q == K_W'(NCHUNK - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == DONE);
    out_r_d     = (state_d == DONE) ? acc_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      opnd_q      <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
    end else begin
      state_q     <= state_d;
      opnd_q      <= opnd_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_r     = out_r_q;
endmodule

// File: tb/tb_mod2011_seq_reducer.sv
// Scoreboard bench for mod2011_seq_reducer: directed corner cases plus random stalls.
module tb_mod2011_seq_reducer;
  logic clk;
  logic rst;

  mod2011_seq_reducer_if ifc ();

  mod2011_seq_reducer dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  int          q[$];
  bit          rst_drv;
  bit          obs_valid;
  logic [10:0] obs_r;
  bit          acc_ev, fire_ev;
  bit          hold_chk;
  logic [10:0] hold_r;

  task automatic check_eq(input string tag, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Observe outputs at negedge, update scoreboard, then drive next inputs
  task automatic step(input bit v, input logic [35:0] x, input bit ordy);
    @(negedge clk);
    obs_valid = ifc.out_valid;
    obs_r     = ifc.out_r;
    acc_ev    = 1'b0;
    fire_ev   = 1'b0;
    check_eq("ready_vs_busy", ifc.in_ready, !ifc.busy);
    if (!obs_valid) check_eq("r_zero_idle", obs_r, 0);
    if (hold_chk) begin
      check_eq("hold_valid", obs_valid, 1);
      check_eq("hold_r", obs_r, hold_r);
    end
    if (rst_drv) begin
      q.delete();
    end else begin
      if (obs_valid && ordy) begin
        fire_ev = 1'b1;
        check_eq("q_nonempty", q.size() > 0, 1);
        if (q.size() > 0) check_eq("result", obs_r, q.pop_front());
      end
      if (v && ifc.in_ready) begin
        acc_ev = 1'b1;
        q.push_back(int'(x % 36'd2011));
      end
    end
    hold_chk      = obs_valid && !ordy && !rst_drv;
    hold_r        = obs_r;
    rst           = rst_drv;
    ifc.in_valid  = v;
    ifc.in_x      = x;
    ifc.out_ready = ordy;
  endtask

  task automatic run_wait(output int edges);
    edges = -1;
    for (int i = 1; i <= 30; i++) begin
      step(1'b0, 36'd0, 1'b0);
      if (obs_valid) begin
        edges = i - 1;
        break;
      end
    end
    check_eq("out_seen", obs_valid, 1);
  endtask

  task automatic finish_one(input string tag, input logic [35:0] x, input int exp);
    int e;
    step(1'b1, x, 1'b0);
    check_eq({tag, "_accept"}, acc_ev, 1);
    run_wait(e);
    check_eq({tag, "_latency"}, e, 6);
    check_eq(tag, obs_r, exp);
    step(1'b0, 36'd0, 1'b1);
  endtask

  initial begin
    int          e;
    int          n_acc, fire_step, acc2_step;
    logic [35:0] cur;
    logic [63:0] r64;
    logic [35:0] x;
    bit          v, ordy;

    rst           = 1'b1;
    rst_drv       = 1'b1;
    hold_chk      = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_x      = '0;
    ifc.out_ready = 1'b0;

    step(1'b0, 36'd0, 1'b0);
    step(1'b0, 36'd0, 1'b0);
    check_eq("rst_in_ready", ifc.in_ready, 1);
    check_eq("rst_out_valid", ifc.out_valid, 0);
    check_eq("rst_busy", ifc.busy, 0);
    check_eq("rst_out_r", ifc.out_r, 0);
    rst_drv = 1'b0;
    step(1'b0, 36'd0, 1'b0);

    finish_one("zero", 36'd0, 0);
    finish_one("x2010", 36'd2010, 2010);
    finish_one("x2011", 36'd2011, 0);
    finish_one("x4022", 36'd4022, 0);
    finish_one("x64", 36'd64, 64);

    // All-ones operand under 10 cycles of backpressure
    step(1'b1, 36'hF_FFFF_FFFF, 1'b0);
    run_wait(e);
    check_eq("ones_latency", e, 6);
    check_eq("ones", obs_r, 1012);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 36'd5, 1'b0);
      check_eq("bp_r", obs_r, 1012);
      check_eq("bp_in_ready", ifc.in_ready, 0);
    end
    step(1'b0, 36'd0, 1'b1);
    step(1'b0, 36'd0, 1'b0);
    check_eq("bp_exit_valid", obs_valid, 0);

    // Back-to-back with in_valid held high
    cur = 36'd2011; n_acc = 0; fire_step = -1; acc2_step = -1;
    for (int i = 0; i < 40; i++) begin
      step(n_acc < 2, cur, 1'b1);
      if (fire_ev && fire_step < 0) fire_step = i;
      if (acc_ev) begin
        n_acc++;
        if (n_acc == 2) acc2_step = i;
        cur = 36'd2010;
      end
      if (n_acc == 2 && q.size() == 0) break;
    end
    check_eq("b2b_accepts", n_acc, 2);
    check_eq("b2b_gap", acc2_step - fire_step, 1);
    check_eq("b2b_drained", q.size(), 0);

    // Reset during RUN aborts the operation
    step(1'b1, 36'd777, 1'b1);
    check_eq("abort_accept", acc_ev, 1);
    step(1'b0, 36'd0, 1'b1);
    step(1'b0, 36'd0, 1'b1);
    rst_drv = 1'b1;
    step(1'b1, 36'd99, 1'b1);
    rst_drv = 1'b0;
    step(1'b0, 36'd0, 1'b1);
    check_eq("abort_in_ready", ifc.in_ready, 1);
    check_eq("abort_out_valid", ifc.out_valid, 0);
    check_eq("abort_busy", ifc.busy, 0);
    finish_one("x12345", 36'd12345, 279);

    // Random operands with random stalls on both sides
    n_acc = 0;
    for (int i = 0; i < 40000 && n_acc < 2500; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 7))
        0:       x = 36'd0;
        1:       x = 36'hF_FFFF_FFFF;
        2:       x = 36'(longint'($urandom_range(0, 34000000)) * 64'd2011);
        default: begin
          r64 = {$urandom(), $urandom()};
          x   = r64[35:0];
        end
      endcase
      step(v, x, ordy);
      if (acc_ev) n_acc++;
    end
    check_eq("rand_accepts", n_acc, 2500);
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 36'd0, 1'b1);
      if (q.size() == 0 && !obs_valid && ifc.in_ready) break;
    end
    check_eq("rand_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
